// File: rtl/fifo_wptr_full_lvl.sv
// rtl/fifo_wptr_full_lvl.sv - write-side pointer, full, level and overflow flags for the gray-pointer FIFO (level logic under FIFO_WLEVEL_EN)
module fifo_wptr_full_lvl #(
    parameter int ADDR_SIZE   = 4,
    parameter int AFULL_LEVEL = 2**ADDR_SIZE - 2
) (
    input  logic                 wclk,
    input  logic                 wrst_n,
    input  logic                 winc,
    input  logic [ADDR_SIZE:0]   wq2_rptr,
    input  logic                 wovf_clr,
    output logic [ADDR_SIZE-1:0] waddr,
    output logic [ADDR_SIZE:0]   wptr,
    output logic                 wfull,
    output logic [ADDR_SIZE:0]   wlevel,
    output logic                 walmost_full,
    output logic                 woverflow
);
    localparam int A = ADDR_SIZE;

    logic [A:0] wbin;
    logic [A:0] wbin_next;
    logic [A:0] wgray_next;
    logic       wpush;
    logic       wfull_next;

    assign wpush      = winc & ~wfull;
    assign wbin_next  = wbin + {{A{1'b0}}, wpush};
    assign wgray_next = (wbin_next >> 1) ^ wbin_next;
    // Full when the next write pointer sits exactly one lap ahead of the synced read pointer.
    assign wfull_next = (wgray_next == {~wq2_rptr[A:A-1], wq2_rptr[A-2:0]});
    assign waddr      = wbin[A-1:0];

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin      <= '0;
            wptr      <= '0;
            wfull     <= 1'b0;
            woverflow <= 1'b0;
        end else begin
            wbin  <= wbin_next;
            wptr  <= wgray_next;
            wfull <= wfull_next;
            if (winc & wfull)
                woverflow <= 1'b1;
            else if (wovf_clr)
                woverflow <= 1'b0;
        end
    end

`ifdef FIFO_WLEVEL_EN
    localparam logic [A:0] AFULL_V = (A+1)'(AFULL_LEVEL);

    logic [A:0] rbin;
    logic [A:0] wlevel_next;

    always_comb begin
        rbin    = '0;
        rbin[A] = wq2_rptr[A];
        for (int i = A - 1; i >= 0; i--)
            rbin[i] = rbin[i+1] ^ wq2_rptr[i];
    end

    // Level is taken against the synced read pointer, so it can only overstate occupancy.
    assign wlevel_next = wbin_next - rbin;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wlevel       <= '0;
            walmost_full <= 1'b0;
        end else begin
            wlevel       <= wlevel_next;
            walmost_full <= (wlevel_next >= AFULL_V);
        end
    end
`else
    assign wlevel       = '0;
    assign walmost_full = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wptr_full_lvl.sv
// tb/tb_fifo_wptr_full_lvl.sv - directed and constrained-random bench for fifo_wptr_full_lvl
module tb_fifo_wptr_full_lvl;
`ifdef FIFO_WLEVEL_EN
    localparam bit LVL = 1'b1;
`else
    localparam bit LVL = 1'b0;
`endif

    logic       wclk = 1'b0;
    logic       wrst_n;
    logic       winc;
    logic [4:0] wq2_rptr;
    logic       wovf_clr;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       wfull;
    logic [4:0] wlevel;
    logic       walmost_full;
    logic       woverflow;

    int vectors    = 0;
    int miscompares = 0;

    fifo_wptr_full_lvl #(.ADDR_SIZE(4), .AFULL_LEVEL(14)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .wq2_rptr(wq2_rptr),
        .wovf_clr(wovf_clr), .waddr(waddr), .wptr(wptr), .wfull(wfull),
        .wlevel(wlevel), .walmost_full(walmost_full), .woverflow(woverflow)
    );

    always #5 wclk = ~wclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [4:0] g(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic test_reset();
        logic [20:0] obs;
        wrst_n = 1'b0; winc = 1'b0; wovf_clr = 1'b0; wq2_rptr = 5'd0;
        #3;
        obs = {waddr, wptr, wfull, wlevel, walmost_full, woverflow};
        vectors++;
        if (obs !== 21'd0) begin
            miscompares++;
            $display("FAIL reset_initial: outputs=%h expected=0", obs);
        end
        tick(); tick();
        wrst_n = 1'b1;
        winc = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        winc = 1'b0;
        vectors++;
        if (waddr !== 4'd7) begin
            miscompares++;
            $display("FAIL reset_prefill_waddr: got=%0d expected=7", waddr);
        end
        #1 wrst_n = 1'b0;
        #2;
        obs = {waddr, wptr, wfull, wlevel, walmost_full, woverflow};
        vectors++;
        if (obs !== 21'd0) begin
            miscompares++;
            $display("FAIL reset_async: outputs=%h expected=0", obs);
        end
        tick(); tick();
        wrst_n = 1'b1;
        tick(); tick();
        obs = {waddr, wptr, wfull, wlevel, walmost_full, woverflow};
        vectors++;
        if (obs !== 21'd0) begin
            miscompares++;
            $display("FAIL reset_hold_after_release: outputs=%h expected=0", obs);
        end
    endtask

    task automatic test_fill();
        logic [4:0] el;
        winc = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            el = LVL ? 5'(i) : 5'd0;
            vectors++;
            if (wlevel !== el) begin
                miscompares++;
                $display("FAIL fill_level[%0d]: got=%0d expected=%0d", i, wlevel, el);
            end
            vectors++;
            if (walmost_full !== (LVL && i >= 14)) begin
                miscompares++;
                $display("FAIL fill_afull[%0d]: got=%b expected=%b", i, walmost_full, (LVL && i >= 14));
            end
            vectors++;
            if (wfull !== (i == 16)) begin
                miscompares++;
                $display("FAIL fill_full[%0d]: got=%b expected=%b", i, wfull, (i == 16));
            end
        end
        winc = 1'b0;
        vectors++;
        if (wptr !== 5'b11000 || waddr !== 4'd0) begin
            miscompares++;
            $display("FAIL fill_ptr: wptr=%b waddr=%0d expected wptr=11000 waddr=0", wptr, waddr);
        end
    endtask

    task automatic test_overflow();
        winc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (wptr !== 5'b11000 || woverflow !== 1'b1 || wfull !== 1'b1) begin
                miscompares++;
                $display("FAIL ovf_set[%0d]: wptr=%b woverflow=%b wfull=%b expected 11000/1/1", i, wptr, woverflow, wfull);
            end
        end
        vectors++;
        if (wlevel !== (LVL ? 5'd16 : 5'd0)) begin
            miscompares++;
            $display("FAIL ovf_level: got=%0d expected=%0d", wlevel, (LVL ? 16 : 0));
        end
        wovf_clr = 1'b1;
        tick();
        vectors++;
        if (woverflow !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_set_wins: got=%b expected=1", woverflow);
        end
        winc = 1'b0;
        tick();
        wovf_clr = 1'b0;
        vectors++;
        if (woverflow !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_clear: got=%b expected=0", woverflow);
        end
        tick();
        vectors++;
        if (woverflow !== 1'b0 || wptr !== 5'b11000) begin
            miscompares++;
            $display("FAIL ovf_after_clear: woverflow=%b wptr=%b expected 0/11000", woverflow, wptr);
        end
    endtask

    task automatic test_drain_refill();
        wq2_rptr = 5'b00001;
        tick();
        vectors++;
        if (wfull !== 1'b0 || wlevel !== (LVL ? 5'd15 : 5'd0) || walmost_full !== LVL) begin
            miscompares++;
            $display("FAIL drain_step: wfull=%b wlevel=%0d afull=%b expected 0/%0d/%b", wfull, wlevel, walmost_full, (LVL ? 15 : 0), LVL);
        end
        winc = 1'b1;
        wq2_rptr = 5'b00011;
        tick();
        winc = 1'b0;
        vectors++;
        if (wfull !== 1'b0 || wlevel !== (LVL ? 5'd15 : 5'd0)) begin
            miscompares++;
            $display("FAIL refill_same_cycle: wfull=%b wlevel=%0d expected 0/%0d", wfull, wlevel, (LVL ? 15 : 0));
        end
        vectors++;
        if (wptr !== 5'b11001 || waddr !== 4'd1) begin
            miscompares++;
            $display("FAIL refill_ptr: wptr=%b waddr=%0d expected 11001/1", wptr, waddr);
        end
    endtask

    task automatic test_wrap();
        logic [4:0] mw, rt, s1, s2, mw_n, el, occ, prev;
        logic       mfull, efull, push, pop;
        wrst_n = 1'b0; winc = 1'b0; wovf_clr = 1'b0; wq2_rptr = 5'd0;
        tick();
        wrst_n = 1'b1;
        tick();
        mw = 0; rt = 0; s1 = 0; s2 = 0; mfull = 1'b0; prev = wptr;
        for (int c = 0; c < 100; c++) begin
            winc = ($urandom_range(0, 3) != 0);
            occ  = mw - rt;
            pop  = ($urandom_range(0, 1) == 1) && (occ != 0);
            push = winc & ~mfull;
            mw_n = mw + {4'd0, push};
            efull = ((mw_n - s2) == 5'd16);
            el   = LVL ? (mw_n - s2) : 5'd0;
            wq2_rptr = g(s2);
            tick();
            mw = mw_n; mfull = efull;
            rt = rt + {4'd0, pop};
            s2 = s1; s1 = rt;
            occ = mw - rt;
            vectors++;
            if (wfull !== efull || (occ == 5'd16 && wfull !== 1'b1)) begin
                miscompares++;
                $display("FAIL wrap_full[%0d]: got=%b expected=%b occupancy=%0d", c, wfull, efull, occ);
            end
            vectors++;
            if (wptr !== g(mw) || $countones(wptr ^ prev) > 1) begin
                miscompares++;
                $display("FAIL wrap_ptr[%0d]: got=%b expected=%b prev=%b", c, wptr, g(mw), prev);
            end
            vectors++;
            if (wlevel !== el || (LVL && wlevel < occ)) begin
                miscompares++;
                $display("FAIL wrap_level[%0d]: got=%0d expected=%0d occupancy=%0d", c, wlevel, el, occ);
            end
            prev = wptr;
        end
        winc = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_drain_refill();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
